// File: rtl/ui_device_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ui_device_responder_pkg
// Description : Shared types and helpers for the UI device responder:
//               uiDevice select encodings (common with IoController) and
//               the hex-digit to 7-segment pattern table.
// Revision    : 1.0 - initial release
// ============================================================================
package ui_device_responder_pkg;

    // Device select codes carried on uiDevice; IoController uses the same values
    typedef enum logic [1:0] {
        UI_DEV_KEY  = 2'd0,
        UI_DEV_SW   = 2'd1,
        UI_DEV_HEX  = 2'd2,
        UI_DEV_LEDR = 2'd3
    } uiDev_e;

    localparam int c_SEG_BITS = 7;

    // Active-low segment pattern, bit order {g,f,e,d,c,b,a}
    function automatic logic [c_SEG_BITS-1:0] sevenSegEncode(input logic [3:0] nibble);
        logic [c_SEG_BITS-1:0] seg;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ui_device_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : ui_device_responder_if
// Description : UI load/store bus between IoController (master) and the
//               device-side responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ui_device_responder_if #(
    parameter int DBITS = 32
) ();

    logic [DBITS-1:0] uiOut;
    logic             uiWrtEn;
    logic             uiRdEn;
    logic [1:0]       uiDevice;
    logic [DBITS-1:0] uiIn;

    modport master (
        output uiOut,
        output uiWrtEn,
        output uiRdEn,
        output uiDevice,
        input  uiIn
    );

    modport slave (
        input  uiOut,
        input  uiWrtEn,
        input  uiRdEn,
        input  uiDevice,
        output uiIn
    );

endinterface
`default_nettype wire

// File: rtl/ui_device_responder_seven_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_decoder
// Description : One hex digit to an active-low 7-segment pattern, full 0-F.
//               Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_decoder (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);
    import ui_device_responder_pkg::*;

    // Table lookup shared through the package so every digit decodes identically
    always_comb begin
        o_seg = sevenSegEncode(i_nibble);
    end

endmodule
`default_nettype wire

// File: rtl/ui_device_responder.sv
`default_nettype none
// ============================================================================
// Module      : ui_device_responder
// Description : Device-side responder for the IoController UI path. Stores
//               drive HEX/LEDR; loads return debounced KEY/SW state. KEY
//               presses latch as sticky events cleared by a KEY read.
// Revision    : 1.0 - initial release
// ============================================================================
module ui_device_responder #(
    parameter int DBITS           = 32,
    parameter int KEY_BITS        = 4,
    parameter int SW_BITS         = 10,
    parameter int LEDR_BITS       = 10,
    parameter int HEX_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    ui_device_responder_if.slave    ui,
    input  logic [KEY_BITS-1:0]     KEY,
    input  logic [SW_BITS-1:0]      SW,
    output logic [7*HEX_DIGITS-1:0] HEX,
    output logic [LEDR_BITS-1:0]    LEDR
);
    import ui_device_responder_pkg::*;

    localparam int c_NBITS   = KEY_BITS + SW_BITS;
    localparam int c_HEXBITS = 4 * HEX_DIGITS;
    // One extra bit of headroom; the counter clears at the threshold so it never wraps
    localparam int c_CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_BITS-1:0]   r_keyMeta;
    logic [KEY_BITS-1:0]   r_keySync;
    logic [SW_BITS-1:0]    r_swMeta;
    logic [SW_BITS-1:0]    r_swSync;
    logic [c_NBITS-1:0]    w_rawSync;
    logic [c_NBITS-1:0]    w_db;
    logic [KEY_BITS-1:0]   w_keyPress;
    logic [KEY_BITS-1:0]   w_keyLevel;
    logic [SW_BITS-1:0]    w_swLevel;
    logic [KEY_BITS-1:0]   r_keyEvents;
    logic                  w_keyRdClr;
    logic [c_HEXBITS-1:0]  r_hexReg;
    logic [LEDR_BITS-1:0]  r_ledr;
    logic [DBITS-1:0]      w_uiIn;

    // Two-flop synchronizers; KEY idles high (released) so its flops reset to 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_keyMeta <= '1;
            r_keySync <= '1;
            r_swMeta  <= '0;
            r_swSync  <= '0;
        end else begin
            r_keyMeta <= KEY;
            r_keySync <= r_keyMeta;
            r_swMeta  <= SW;
            r_swSync  <= r_swMeta;
        end
    end

    // Internal polarity is 1 = active for both inputs, so KEY is inverted here
    assign w_rawSync = {r_swSync, ~r_keySync};

    generate
        for (genvar i = 0; i < c_NBITS; i++) begin : g_debounce
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_dbBit;
            logic               w_take;

            assign w_take = (w_rawSync[i] != r_dbBit) && (r_cnt == c_CNT_MAX);
            assign w_db[i] = r_dbBit;

            // Count consecutive differing cycles; adopt the new value at the threshold
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt   <= '0;
                    r_dbBit <= 1'b0;
                end else if (w_rawSync[i] == r_dbBit) begin
                    r_cnt   <= '0;
                end else if (w_take) begin
                    r_dbBit <= w_rawSync[i];
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end

            // Press edge fires on the same edge the debounced level rises
            if (i < KEY_BITS) begin : g_keyEdge
                assign w_keyPress[i] = w_take & w_rawSync[i];
            end
        end
    endgenerate

    assign w_keyLevel = w_db[KEY_BITS-1:0];
    assign w_swLevel  = w_db[c_NBITS-1:KEY_BITS];
    assign w_keyRdClr = ui.uiRdEn && (uiDev_e'(ui.uiDevice) == UI_DEV_KEY);

    // Sticky press events; a new press in the clearing cycle survives the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_keyEvents <= '0;
        end else begin
            r_keyEvents <= (w_keyRdClr ? '0 : r_keyEvents) | w_keyPress;
        end
    end

    // Store path: only HEX and LEDR hold writable state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hexReg <= '0;
            r_ledr   <= '0;
        end else if (ui.uiWrtEn) begin
            case (uiDev_e'(ui.uiDevice))
                UI_DEV_HEX:  r_hexReg <= ui.uiOut[c_HEXBITS-1:0];
                UI_DEV_LEDR: r_ledr   <= ui.uiOut[LEDR_BITS-1:0];
                default:     ;
            endcase
        end
    end

    // Load path: zero-extended view of the selected device's registered state
    always_comb begin
        w_uiIn = '0;
        case (uiDev_e'(ui.uiDevice))
            UI_DEV_KEY:  w_uiIn[2*KEY_BITS-1:0] = {r_keyEvents, w_keyLevel};
            UI_DEV_SW:   w_uiIn[SW_BITS-1:0]    = w_swLevel;
            UI_DEV_HEX:  w_uiIn[c_HEXBITS-1:0]  = r_hexReg;
            default:     w_uiIn[LEDR_BITS-1:0]  = r_ledr;
        endcase
    end

    assign ui.uiIn = w_uiIn;
    assign LEDR    = r_ledr;

    generate
        for (genvar d = 0; d < HEX_DIGITS; d++) begin : g_hexDigit
            seven_seg_decoder u_dec (
                .i_nibble (r_hexReg[4*d +: 4]),
                .o_seg    (HEX[7*d +: 7])
            );
        end
    endgenerate

endmodule
`default_nettype wire
